// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encoding, run status
// codes and the halt/timeout priority helper.
package run_ctrl_pkg;

    // Controller states. Plain constants keep the encoding visible to older
    // tools and to anyone probing state_q in a waveform viewer.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DUMP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Run status reported on the status output.
    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Resolve the end-of-run reason. A halt seen in the same cycle as the
    // timeout is reported as a halt: the program did finish.
    function automatic logic [1:0] run_status(input logic halt, input logic timeout);
        logic [1:0] code;
        code = ST_RUN;
        if (halt) begin
            code = ST_HALT;
        end else if (timeout) begin
            code = ST_TIMEOUT;
        end
        return code;
    endfunction

endpackage

// File: rtl/run_ctrl_pc_stall.sv
// PC stall detector: remembers the last valid PC seen while the core runs
// and counts consecutive valid samples that repeat it. A core spinning on a
// self-branch is treated as halted once the repeat count hits the limit.
module pc_stall_detect
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            stall_hit_o
);

    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    // Count value at which one more repeat constitutes a stall.
    localparam logic [SC_W-1:0] CNT_TOP = SC_W'(STALL_LIMIT - 1);

    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            have_pc_q, have_pc_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            same_pc;

    // A repeat only counts once a reference PC has been captured this run,
    // so whatever value last_pc held before the run can never match.
    always_comb begin
        same_pc = enable_i && pc_valid_i && have_pc_q && (pc_i == last_pc_q);
    end

    assign stall_hit_o = same_pc && (stall_cnt_q == CNT_TOP);

    // Next-state for the reference PC and the repeat counter. Invalid
    // samples leave everything untouched so bubbles do not break a stall.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the if/else leaves it unassigned and no latch is inferred.
        last_pc_d   = last_pc_q;
        have_pc_d   = have_pc_q;
        stall_cnt_d = stall_cnt_q;
        if (clear_i) begin
            last_pc_d   = '0;
            have_pc_d   = 1'b0;
            stall_cnt_d = '0;
        end else if (enable_i && pc_valid_i) begin
            if (same_pc) begin
                if (stall_cnt_q != CNT_TOP) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end else begin
                last_pc_d   = pc_i;
                have_pc_d   = 1'b1;
                stall_cnt_d = '0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc_q   <= '0;
            have_pc_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs, independent of order.
            last_pc_q   <= last_pc_d;
            have_pc_q   <= have_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences a processor core through a held reset, a
// budgeted run with halt/stall/timeout detection, and a valid/ready walk of
// the data cache for dumping. Every output comes straight from a register.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 100000,
    parameter int CNT_W        = 32,
    parameter int PC_W         = 32,
    parameter int STALL_LIMIT  = 16,
    parameter int DUMP_WORDS   = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   pc,
    input  logic              pc_valid,
    input  logic              halt_insn,
    output logic              core_nrst,
    output logic              core_en,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done,
    output logic [1:0]        status
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DUMP_WORDS - 1);

    logic [2:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              core_nrst_q, core_nrst_d;
    logic              core_en_q, core_en_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic              dump_valid_q, dump_valid_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              done_q, done_d;
    logic [1:0]        status_q, status_d;

    logic stall_clear;
    logic stall_hit;
    logic in_run;
    logic halt_det;
    logic timeout_det;

    assign in_run = (state_q == S_RUN);

    pc_stall_detect #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (stall_clear),
        .enable_i    (in_run),
        .pc_i        (pc),
        .pc_valid_i  (pc_valid),
        .stall_hit_o (stall_hit)
    );

    // End-of-run conditions, only meaningful while the core is running.
    always_comb begin
        halt_det    = in_run && (halt_insn || stall_hit);
        timeout_det = in_run && (cycle_count_q == CNT_LAST);
    end

    // Controller next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        core_nrst_d   = core_nrst_q;
        core_en_d     = core_en_q;
        dump_addr_d   = dump_addr_q;
        dump_valid_d  = dump_valid_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        status_d      = status_q;
        stall_clear   = 1'b0;

        case (state_q)
            // A finished run may be restarted exactly like an idle one.
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_RESET;
                    hold_d        = '0;
                    core_nrst_d   = 1'b0;
                    core_en_d     = 1'b1;
                    dump_addr_d   = '0;
                    dump_valid_d  = 1'b0;
                    cycle_count_d = '0;
                    done_d        = 1'b0;
                    status_d      = ST_RUN;
                    stall_clear   = 1'b1;
                end
            end

            // Core is clocked but held in reset for RESET_CYCLES cycles.
            S_RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d     = S_RUN;
                    core_nrst_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            // Core runs; the detecting cycle freezes the count and the core.
            S_RUN: begin
                if (halt_det || timeout_det) begin
                    state_d      = S_DUMP;
                    status_d     = run_status(halt_det, timeout_det);
                    core_en_d    = 1'b0;
                    dump_valid_d = 1'b1;
                    dump_addr_d  = '0;
                end else if (cycle_count_q != CNT_SAT) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
            end

            // Walk the dcache one accepted word at a time.
            S_DUMP: begin
                if (dump_valid_q && dump_ready) begin
                    if (dump_addr_q == ADDR_LAST) begin
                        state_d      = S_DONE;
                        dump_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        dump_addr_d = dump_addr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered state and outputs; rst abandons anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            core_nrst_q   <= 1'b0;
            core_en_q     <= 1'b0;
            dump_addr_q   <= '0;
            dump_valid_q  <= 1'b0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            status_q      <= ST_RUN;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            core_nrst_q   <= core_nrst_d;
            core_en_q     <= core_en_d;
            dump_addr_q   <= dump_addr_d;
            dump_valid_q  <= dump_valid_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            status_q      <= status_d;
        end
    end

    assign core_nrst   = core_nrst_q;
    assign core_en     = core_en_q;
    assign dump_addr   = dump_addr_q;
    assign dump_valid  = dump_valid_q;
    assign cycle_count = cycle_count_q;
    assign done        = done_q;
    assign status      = status_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed testbench for run_ctrl: reset hold, halt instruction, PC stall,
// timeout and halt/timeout collision, dump backpressure, async reset mid-dump.
module tb_run_ctrl;

    localparam int RC = 4;
    localparam int MC = 1000;
    localparam int SL = 16;
    localparam int DW = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        pc_valid;
    logic        halt_insn;
    logic        core_nrst;
    logic        core_en;
    logic [7:0]  dump_addr;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] cycle_count;
    logic        done;
    logic [1:0]  status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    run_ctrl #(
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MC),
        .CNT_W        (32),
        .PC_W         (32),
        .STALL_LIMIT  (SL),
        .DUMP_WORDS   (DW),
        .ADDR_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .halt_insn   (halt_insn),
        .core_nrst   (core_nrst),
        .core_en     (core_en),
        .dump_addr   (dump_addr),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .cycle_count (cycle_count),
        .done        (done),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start and walk through the reset hold into RUN.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_en", 32'(core_en), 1);
        check("hold_nrst", 32'(core_nrst), 0);
        check("hold_done", 32'(done), 0);
        check("hold_status", 32'(status), 0);
        for (int i = 1; i < RC; i++) begin
            tick();
            check("hold_nrst", 32'(core_nrst), 0);
        end
        tick();
        check("run_nrst", 32'(core_nrst), 1);
        check("run_en", 32'(core_en), 1);
        check("run_count0", cycle_count, 0);
    endtask

    // Accept all dump words; optional 1,0,1,0 ready pattern and a stray start.
    task automatic do_dump(input bit toggle, input bit poke_start);
        int  exp_addr;
        int  n;
        bit  rdy;
        exp_addr = 0;
        n        = 0;
        rdy      = 1'b1;
        while (exp_addr < DW && n < 200) begin
            dump_ready = rdy;
            if (toggle) rdy = ~rdy;
            start = poke_start && (n == 5);
            if (dump_valid && dump_ready) begin
                check("dump_addr", 32'(dump_addr), 32'(exp_addr));
                if (exp_addr == DW - 1) check("done_early", 32'(done), 0);
                exp_addr++;
            end
            tick();
            n++;
            if (poke_start && n == 6) check("start_ignored", 32'(core_nrst), 1);
        end
        start      = 1'b0;
        dump_ready = 1'b0;
        if (exp_addr < DW) check("dump_bound", 32'(exp_addr), DW);
        if (!toggle) check("dump_cycles", 32'(n), DW);
        check("done", 32'(done), 1);
        check("dump_valid_off", 32'(dump_valid), 0);
        check("done_en", 32'(core_en), 0);
        check("done_nrst", 32'(core_nrst), 1);
        tick();
        check("done_hold", 32'(done), 1);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        int          n;
    } seg_t;

    seg_t segs[6];

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pc         = '0;
        pc_valid   = 1'b0;
        halt_insn  = 1'b0;
        dump_ready = 1'b0;
        #3;
        check("rst_nrst", 32'(core_nrst), 0);
        check("rst_en", 32'(core_en), 0);
        check("rst_dvalid", 32'(dump_valid), 0);
        check("rst_daddr", 32'(dump_addr), 0);
        check("rst_count", cycle_count, 0);
        check("rst_done", 32'(done), 0);
        check("rst_status", 32'(status), 0);
        #4 rst = 1'b0;

        // Reset hold: start sampled at edge 10, then halt 50 cycles into RUN.
        while (cyc < 9) tick();
        check("idle_en", 32'(core_en), 0);
        start_run();
        repeat (50) tick();
        check("pre_halt_count", cycle_count, 50);
        check("pre_halt_status", 32'(status), 0);
        halt_insn = 1'b1;
        tick();
        halt_insn = 1'b0;
        check("halt_status", 32'(status), 1);
        check("halt_count", cycle_count, 50);
        check("halt_en", 32'(core_en), 0);
        check("halt_nrst", 32'(core_nrst), 1);
        check("halt_dvalid", 32'(dump_valid), 1);
        check("halt_daddr", 32'(dump_addr), 0);
        do_dump(1'b1, 1'b1);
        check("halt_count_frozen", cycle_count, 50);
        check("halt_status_hold", 32'(status), 1);

        // PC stall: gaps keep the count, a new PC restarts it.
        segs[0] = '{32'h40, 1'b1, 1};
        segs[1] = '{32'h40, 1'b1, 5};
        segs[2] = '{32'h40, 1'b0, 3};
        segs[3] = '{32'h44, 1'b1, 1};
        segs[4] = '{32'h44, 1'b1, SL - 1};
        segs[5] = '{32'h44, 1'b0, 2};
        start_run();
        foreach (segs[s]) begin
            pc       = segs[s].pc;
            pc_valid = segs[s].valid;
            repeat (segs[s].n) tick();
        end
        check("stall_pending_status", 32'(status), 0);
        check("stall_pending_en", 32'(core_en), 1);
        check("stall_pending_count", cycle_count, 27);
        pc       = 32'h44;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("stall_status", 32'(status), 1);
        check("stall_count", cycle_count, 27);
        check("stall_en", 32'(core_en), 0);
        do_dump(1'b0, 1'b0);

        // Timeout with no halt.
        start_run();
        repeat (MC - 1) tick();
        check("pre_to_count", cycle_count, MC - 1);
        check("pre_to_status", 32'(status), 0);
        check("pre_to_en", 32'(core_en), 1);
        tick();
        check("to_status", 32'(status), 2);
        check("to_count", cycle_count, MC - 1);
        check("to_en", 32'(core_en), 0);
        check("to_dvalid", 32'(dump_valid), 1);
        do_dump(1'b0, 1'b0);
        check("to_count_hold", cycle_count, MC - 1);

        // Halt colliding with timeout: halt wins.
        start_run();
        repeat (MC - 1) tick();
        halt_insn = 1'b1;
        tick();
        halt_insn = 1'b0;
        check("coll_status", 32'(status), 1);
        check("coll_count", cycle_count, MC - 1);

        // Async reset mid-dump at address 3.
        dump_ready = 1'b1;
        repeat (3) tick();
        check("abort_daddr", 32'(dump_addr), 3);
        check("abort_dvalid", 32'(dump_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_nrst", 32'(core_nrst), 0);
        check("abort_en", 32'(core_en), 0);
        check("abort_dvalid0", 32'(dump_valid), 0);
        check("abort_daddr0", 32'(dump_addr), 0);
        check("abort_count", cycle_count, 0);
        check("abort_done", 32'(done), 0);
        check("abort_status", 32'(status), 0);
        #2 rst = 1'b0;
        dump_ready = 1'b0;
        tick();
        check("post_abort_idle_en", 32'(core_en), 0);

        // Fresh run after the abort.
        start_run();
        repeat (7) tick();
        check("rerun_count", cycle_count, 7);
        halt_insn = 1'b1;
        tick();
        halt_insn = 1'b0;
        check("rerun_status", 32'(status), 1);
        check("rerun_count_frozen", cycle_count, 7);
        do_dump(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesisable run controller that sequences a Processor core through reset, run, halt detection and data-cache dump. It replaces a fixed-length reset pulse and a fixed cycle budget with parametrised reset hold, halt-instruction and PC-stall detection, a saturating timeout, and a valid/ready dump walk. It sits between the top-level clock/reset and a Processor instance, driving the core's active-low reset and clock enable, and feeding the dcache dump port.

## Interface
Parameters:
- RESET_CYCLES, 4: cycles core_nrst is held low after start.
- MAX_CYCLES, 100000: RUN-cycle budget before timeout.
- CNT_W, 32: cycle counter width; MAX_CYCLES < 2^CNT_W.
- PC_W, 32: program counter width.
- STALL_LIMIT, 16: consecutive valid cycles with an unchanged PC that count as a halt.
- DUMP_WORDS, 256: number of dcache words walked in DUMP.
- ADDR_W, 8: dump address width; DUMP_WORDS ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run.
- pc  in  PC_W  core program counter.
- pc_valid  in  1  pc is meaningful this cycle.
- halt_insn  in  1  core retired a halt instruction.
- core_nrst  out  1  active-low reset to the core.
- core_en  out  1  core clock enable.
- dump_addr  out  ADDR_W  dcache word address being requested.
- dump_valid  out  1  dump_addr is valid.
- dump_ready  in  1  dump sink accepts dump_addr.
- cycle_count  out  CNT_W  RUN cycles elapsed; saturating.
- done  out  1  run and dump complete.
- status  out  2  00 idle/running, 01 halted, 10 timeout.

## Operation
- States: IDLE, RESET, RUN, DUMP, DONE.
- IDLE: core_nrst=0, core_en=0. When start=1 → RESET, clear cycle_count, status, and the stall counter.
- RESET: core_nrst=0, core_en=1. A hold counter counts RESET_CYCLES cycles, then → RUN.
- RUN: core_nrst=1, core_en=1. cycle_count increments by 1 each cycle.
  - Stall counter: increments when pc_valid and pc equals the last registered pc. Resets to 0 when pc_valid and pc differs. Holds when pc_valid=0.
  - Halt condition: halt_insn=1, or the stall counter reaches STALL_LIMIT-1 with another equal valid pc. Sets status=01 and goes → DUMP.
  - Timeout condition: cycle_count reaches MAX_CYCLES-1 in RUN. Sets status=10 and goes → DUMP.
  - If halt and timeout occur in the same cycle, halt wins (status=01).
- DUMP: core_nrst=1, core_en=0 (core frozen; dcache contents preserved). dump_valid=1, with dump_addr starting at 0.
  - dump_addr advances only on dump_valid&&dump_ready.
  - Acceptance at DUMP_WORDS-1 → DONE, with dump_valid deasserted the next cycle.
- DONE: done=1, core_en=0, core_nrst=1. status and cycle_count hold. start=1 → RESET (a new run).
- start is ignored in RESET, RUN and DUMP.
- rst at any time, including mid-DUMP: all state returns to IDLE asynchronously. A partial dump is abandoned.

## Timing
- Reset values: core_nrst=0, core_en=0, dump_valid=0, dump_addr=0, cycle_count=0, done=0, status=00, state=IDLE.
- All outputs are registered; no combinational path from any input to any output.
- start sampled at edge N: core_nrst low for edges N+1..N+RESET_CYCLES; core_nrst=1 after edge N+RESET_CYCLES+1.
- Halt/timeout detection to core_en=0: 1 cycle. cycle_count does not increment in the detecting cycle's successor.
- Dump throughput: 1 word/cycle with dump_ready held high. done rises 1 cycle after the final handshake.
- cycle_count saturates at 2^CNT_W-1, which is only reachable if the parameter constraint is violated.

## Structure
- Shared package run_ctrl_pkg: state encoding (IDLE/RESET/RUN/DUMP/DONE) and status codes (ST_RUN=2'b00, ST_HALT=2'b01, ST_TIMEOUT=2'b10).
- One sub-module, pc_stall_detect: registered last-pc, stall counter, and a stall-hit output. Cleared when entering RESET.

## Test plan
- Reset hold: RESET_CYCLES=4, start pulse at cycle 10 → core_nrst=0 on cycles 11–14, 1 from cycle 15; core_en=1 from cycle 11.
- Halt instruction: halt_insn pulse 50 cycles into RUN → status=01, cycle_count=50 frozen, core_en=0 next cycle, dump begins at addr 0.
- PC stall: STALL_LIMIT=16, pc held at 0x40 with pc_valid=1 → halt on the 16th equal sample. Gaps in pc_valid=0 do not reset the count; pc changing to 0x44 does.
- Timeout with collision: MAX_CYCLES=1000, no halt → status=10 at cycle_count=999. Repeat with halt_insn asserted on that same cycle → status=01.
- Dump backpressure: DUMP_WORDS=8, dump_ready toggling 1,0,1,0 → addresses 0..7 each accepted exactly once, in order. done=1 one cycle after addr 7 is accepted. A start pulse mid-dump is ignored.
- Async reset mid-DUMP at addr 3 → all outputs at reset values within the same cycle. A new start then runs a full sequence with cycle_count starting at 0.
